btn_conditioner: RTL and testbench

Conditions the five raw Basys3 push-buttons (left, center, right, down, up) into clean single-cycle pulses for the cursor stage, which moves one grid step per pulse. Each button is synchronised with 2 FFs, debounced on press and release by an independent 4-state FSM, and emits exactly one pulse per accepted press. It sits between the top-level button pins and the cursor block's left/center/right/down/up inputs.

---
 rtl/btn_conditioner.sv | 181 ++++++++++++++++++
 tb/tb_btn_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: syncs, debounces and pulses the five push-buttons.
// Define BTN_AUTOREPEAT_EN to auto-repeat left/right/down/up while held.
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_left,
   input  logic       btn_center,
   input  logic       btn_right,
   input  logic       btn_down,
   input  logic       btn_up,
   output logic       left,
   output logic       center,
   output logic       right,
   output logic       down,
   output logic       up,
   output logic [4:0] held
);

   localparam int N = 5;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
   localparam logic [1:0] ST_HELD       = 2'd2;
   localparam logic [1:0] ST_REL_WAIT   = 2'd3;

   localparam logic [CNT_W-1:0] DB_LAST =
      CNT_W'(DEBOUNCE_CYCLES - 1);

   // Illegal parameter sets elaborate this block (easy to spot).
   if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 ||
       REPEAT_DELAY < 1 || CNT_W < 1) begin : g_bad_cfg
      logic bad_cfg;
      assign bad_cfg = 1'b1;
   end

   logic [N-1:0] raw;
   assign raw = {btn_up, btn_down, btn_right, btn_center, btn_left};

   logic [N-1:0]     sync1_q, sync1_d;
   logic [N-1:0]     sync2_q, sync2_d;
   logic [1:0]       state_q [N];
   logic [1:0]       state_d [N];
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];
   logic [N-1:0]     pulse_q, pulse_d;
   logic [N-1:0]     held_q, held_d;

`ifdef BTN_AUTOREPEAT_EN
   // Center is fire/select and never repeats.
   localparam logic [N-1:0] RPT_MASK = 5'b11101;
   localparam logic [CNT_W-1:0] DLY_LAST =
      CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST =
      CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rcnt_q [N];
   logic [CNT_W-1:0] rcnt_d [N];
   logic [N-1:0]     rphase_q, rphase_d;
`endif

   // Two-flop synchroniser for the asynchronous button pins.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
   end

   // Per-button debounce FSM; s = sync2_q.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         pulse_d[i] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_d[i]   = rcnt_q[i];
         rphase_d[i] = rphase_q[i];
`endif
         unique case (state_q[i])
            ST_IDLE: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_PRESS_WAIT;
                  cnt_d[i]   = '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = ST_HELD;
                  cnt_d[i]   = '0;
                  pulse_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                  rcnt_d[i]   = '0;
                  rphase_d[i] = 1'b0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            ST_HELD: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_REL_WAIT;
                  cnt_d[i]   = '0;
               end
`ifdef BTN_AUTOREPEAT_EN
               else if (RPT_MASK[i]) begin
                  if (rcnt_q[i] ==
                      (rphase_q[i] ? PER_LAST : DLY_LAST)) begin
                     pulse_d[i]  = 1'b1;
                     rcnt_d[i]   = '0;
                     rphase_d[i] = 1'b1;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
                  end
               end
`endif
            end
            ST_REL_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_HELD;
               end else if (cnt_q[i] == DB_LAST) begin
                  state_d[i] = ST_IDLE;
                  cnt_d[i]   = '0;
`ifdef BTN_AUTOREPEAT_EN
                  rcnt_d[i]   = '0;
                  rphase_d[i] = 1'b0;
`endif
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         held_d[i] = (state_d[i] == ST_HELD) ||
                     (state_d[i] == ST_REL_WAIT);
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         pulse_q <= '0;
         held_q  <= '0;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
`ifdef BTN_AUTOREPEAT_EN
         rphase_q <= '0;
         for (int i = 0; i < N; i++) rcnt_q[i] <= '0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         pulse_q <= pulse_d;
         held_q  <= held_d;
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
`ifdef BTN_AUTOREPEAT_EN
         rphase_q <= rphase_d;
         for (int i = 0; i < N; i++) rcnt_q[i] <= rcnt_d[i];
`endif
      end
   end

   assign {up, down, right, center, left} = pulse_q;
   assign held = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed edge checks plus random stimulus
// against a run-length reference model of the debouncer.
module tb_btn_conditioner;

   localparam int D  = 4;
   localparam int RD = 8;
   localparam int RP = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] raw = '0;
   logic       left, center, right, down, up;
   logic [4:0] held;

   int n_checks = 0;
   int n_err = 0;

   // model: 2-deep sync, run lengths, press state, hold ticks
   logic [4:0] m_s1, m_s2, exp_pulse;
   bit   [4:0] pressed;
   int         run [5];
   int         ticks [5];

   btn_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(4),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_left(raw[0]),
      .btn_center(raw[1]),
      .btn_right(raw[2]),
      .btn_down(raw[3]),
      .btn_up(raw[4]),
      .left(left),
      .center(center),
      .right(right),
      .down(down),
      .up(up),
      .held(held)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic [4:0] pulses();
      return {up, down, right, center, left};
   endfunction

   task automatic model_reset();
      m_s1 = '0;
      m_s2 = '0;
      exp_pulse = '0;
      pressed = '0;
      for (int i = 0; i < 5; i++) begin
         run[i] = 0;
         ticks[i] = 0;
      end
   endtask

   // One clock edge of the reference: a press is accepted after
   // D+1 consecutive 1 samples, a release after D+1 zeros.
   task automatic model_edge();
      logic [4:0] s;
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = raw;
      for (int i = 0; i < 5; i++) begin
         exp_pulse[i] = 1'b0;
         if (!pressed[i]) begin
            run[i] = s[i] ? run[i] + 1 : 0;
            if (run[i] == D + 1) begin
               pressed[i] = 1'b1;
               run[i] = 0;
               ticks[i] = 0;
               exp_pulse[i] = 1'b1;
            end
         end else begin
`ifdef BTN_AUTOREPEAT_EN
            if (run[i] == 0 && s[i] && i != 1) begin
               ticks[i]++;
               if (ticks[i] >= RD && (ticks[i] - RD) % RP == 0)
                  exp_pulse[i] = 1'b1;
            end
`endif
            run[i] = s[i] ? 0 : run[i] + 1;
            if (run[i] == D + 1) begin
               pressed[i] = 1'b0;
               run[i] = 0;
            end
         end
      end
   endtask

   // Drive at negedge, clock once, compare at the next negedge.
   task automatic step(input logic [4:0] r);
      raw = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("pulse", 32'(pulses()), 32'(exp_pulse));
      check("held", 32'(held), 32'(pressed));
   endtask

   task automatic do_reset(input logic [4:0] r);
      raw = r;
      rst_n = 1'b0;
      #1;
      check("rst_out", 32'({pulses(), held}), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [4:0] r;
      model_reset();
      @(negedge clk);
      do_reset('0);

      // clean right press
      for (int k = 1; k <= 12; k++) begin
         step(5'b00100);
         check("t1_pulse", 32'(pulses()),
               (k == 7) ? 32'h4 : 32'h0);
         check("t1_held", 32'(held[2]), 32'(k >= 7));
      end

      // up toggling then steady
      do_reset('0);
      for (int k = 0; k < 10; k++) begin
         step((k % 2 == 0) ? 5'b10000 : 5'b00000);
         check("t2_tog", 32'(up), 32'h0);
      end
      for (int k = 1; k <= 10; k++) begin
         step(5'b10000);
         check("t2_up", 32'(up), 32'(k == 7));
      end

      // left with release glitch
      do_reset('0);
      for (int k = 1; k <= 24; k++) begin
         if (k <= 10) r = 5'b00001;
         else if (k <= 12) r = 5'b00000;
         else if (k <= 15) r = 5'b00001;
         else r = 5'b00000;
         step(r);
         check("t3_left", 32'(left), 32'(k == 7));
         if (k >= 7 && k <= 17)
            check("t3_held", 32'(held[0]), 32'h1);
      end
      check("t3_rel", 32'(held[0]), 32'h0);

      // simultaneous left and down
      do_reset('0);
      for (int k = 1; k <= 9; k++) begin
         step(5'b01001);
         check("t4_pulse", 32'(pulses()),
               (k == 7) ? 32'h9 : 32'h0);
      end

      // reset during center PRESS_WAIT
      do_reset('0);
      for (int k = 1; k <= 4; k++) step(5'b00010);
      do_reset(5'b00010);
      for (int k = 1; k <= 9; k++) begin
         step(5'b00010);
         check("t5_center", 32'(center), 32'(k == 7));
      end

      // right and center held 30 cycles
      do_reset('0);
      for (int k = 1; k <= 30; k++) begin
         step(5'b00110);
`ifdef BTN_AUTOREPEAT_EN
         check("t6_right", 32'(right),
               32'(k == 7 || (k >= 15 && (k - 15) % 3 == 0)));
`else
         check("t6_right", 32'(right), 32'(k == 7));
`endif
         check("t6_center", 32'(center), 32'(k == 7));
      end

      // random bouncy stimulus
      do_reset('0);
      r = '0;
      for (int n = 0; n < 2400; n++) begin
         int lim;
         lim = ((n / 200) % 3 == 0) ? 2 : ((n / 200) % 3 == 1) ? 7 : 25;
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, lim - 1) == 0) r[b] = ~r[b];
         if (n % 700 == 350) do_reset(r);
         step(r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
